// File: rtl/elevator_scheduler_if.sv
// Call-button and car-status bundle between the button panel and the scheduler.
interface elevator_scheduler_if #(
    parameter int unsigned NUM_FLOORS = 8,
    parameter int unsigned FLOOR_W    = 3
);
    logic [NUM_FLOORS-1:0] call_req;
    logic [NUM_FLOORS-1:0] pending;
    logic [FLOOR_W-1:0]    current_floor;
    logic                  direction;
    logic                  moving;
    logic                  door_open;
    logic                  arrived;

    // Button panel / supervisor side
    modport master (
        output call_req,
        input  pending, current_floor, direction, moving, door_open, arrived
    );

    // Scheduler side
    modport slave (
        input  call_req,
        output pending, current_floor, direction, moving, door_open, arrived
    );
endinterface

// File: rtl/elevator_scheduler.sv
// LOOK-scheduling elevator controller: latches floor calls, steps the car one floor per
// MOVE_CYCLES and holds the door open DOOR_CYCLES at every served floor.
module elevator_scheduler #(
    parameter int unsigned NUM_FLOORS  = 8,
    parameter int unsigned FLOOR_W     = 3,
    parameter int unsigned MOVE_CYCLES = 4,
    parameter int unsigned DOOR_CYCLES = 3
) (
    input  logic               clock,
    input  logic               reset_n,
    elevator_scheduler_if.slave bus
);

    localparam int unsigned CntW  = $clog2(NUM_FLOORS + 1);
    localparam int unsigned MoveW = $clog2(MOVE_CYCLES + 1);
    localparam int unsigned DoorW = $clog2(DOOR_CYCLES + 1);
    localparam logic [MoveW-1:0] MoveLast = MoveW'(MOVE_CYCLES - 1);
    localparam logic [DoorW-1:0] DoorLast = DoorW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StMove, StDoor} state_e;

    state_e                state_q, state_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic                  dir_q, dir_d;
    logic                  arrived_q, arrived_d;
    logic [MoveW-1:0]      move_cnt_q, move_cnt_d;
    logic [DoorW-1:0]      door_cnt_q, door_cnt_d;

    logic                  above_cur, below_cur;
    logic [CntW-1:0]       n_above, n_below;
    logic [FLOOR_W-1:0]    floor_step;
    logic                  above_nxt, below_nxt;
    logic [NUM_FLOORS-1:0] call_eff;

    // Neighbouring floor in the travel direction; only used while travelling toward a call.
    assign floor_step = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

    // Latched calls above/below the current floor, with popcounts for the idle tie-break.
    always_comb begin
        above_cur = 1'b0;
        below_cur = 1'b0;
        n_above   = '0;
        n_below   = '0;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (pending_q[i]) begin
                if (i > int'(floor_q)) begin
                    above_cur = 1'b1;
                    n_above   = n_above + CntW'(1);
                end else if (i < int'(floor_q)) begin
                    below_cur = 1'b1;
                    n_below   = n_below + CntW'(1);
                end
            end
        end
    end

    // Latched calls above/below the floor about to be reached.
    always_comb begin
        above_nxt = 1'b0;
        below_nxt = 1'b0;
        for (int i = 0; i < int'(NUM_FLOORS); i++) begin
            if (pending_q[i] && (i > int'(floor_step))) above_nxt = 1'b1;
            if (pending_q[i] && (i < int'(floor_step))) below_nxt = 1'b1;
        end
    end

    // Next-state: scheduling decisions, timers and call latching.
    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        arrived_d  = 1'b0;
        move_cnt_d = move_cnt_q;
        door_cnt_d = door_cnt_q;
        pending_d  = pending_q;

        // A call at the floor whose door is already open is absorbed, not latched.
        call_eff = bus.call_req;
        if (state_q == StDoor) call_eff[floor_q] = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pending_q[floor_q]) begin
                    state_d    = StDoor;
                    door_cnt_d = '0;
                end else if (above_cur || below_cur) begin
                    state_d    = StMove;
                    move_cnt_d = '0;
                    // More calls wins; a tie goes up; one-sided picks that side.
                    dir_d      = (n_above >= n_below);
                end
            end
            StMove: begin
                if (move_cnt_q == MoveLast) begin
                    floor_d    = floor_step;
                    arrived_d  = 1'b1;
                    move_cnt_d = '0;
                    if (pending_q[floor_step]) begin
                        state_d    = StDoor;
                        door_cnt_d = '0;
                    end else if (dir_q ? above_nxt : below_nxt) begin
                        state_d = StMove;
                    end else if (dir_q ? below_nxt : above_nxt) begin
                        dir_d = ~dir_q;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    move_cnt_d = move_cnt_q + MoveW'(1);
                end
            end
            StDoor: begin
                if (bus.call_req[floor_q]) begin
                    door_cnt_d = '0;
                end else if (door_cnt_q == DoorLast) begin
                    door_cnt_d = '0;
                    if (dir_q ? above_cur : below_cur) begin
                        state_d    = StMove;
                        move_cnt_d = '0;
                    end else if (dir_q ? below_cur : above_cur) begin
                        state_d    = StMove;
                        move_cnt_d = '0;
                        dir_d      = ~dir_q;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    door_cnt_d = door_cnt_q + DoorW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        pending_d = pending_q | call_eff;
        // Serving a floor clears its call, even one arriving in the same cycle.
        if ((state_d == StDoor) && (state_q != StDoor)) pending_d[floor_d] = 1'b0;
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            pending_q  <= '0;
            floor_q    <= '0;
            dir_q      <= 1'b1;
            arrived_q  <= 1'b0;
            move_cnt_q <= '0;
            door_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            floor_q    <= floor_d;
            dir_q      <= dir_d;
            arrived_q  <= arrived_d;
            move_cnt_q <= move_cnt_d;
            door_cnt_q <= door_cnt_d;
        end
    end

    assign bus.pending       = pending_q;
    assign bus.current_floor = floor_q;
    assign bus.direction     = dir_q;
    assign bus.moving        = (state_q == StMove);
    assign bus.door_open     = (state_q == StDoor);
    assign bus.arrived       = arrived_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: a cycle model of the LOOK rules runs alongside the DUT and is
// compared every cycle; directed scenarios add hand-computed expectations.
module tb_elevator_scheduler;

    localparam int NF = 8;
    localparam int MC = 4;
    localparam int DC = 3;

    logic clock;
    logic reset_n;

    elevator_scheduler_if #(.NUM_FLOORS(NF), .FLOOR_W(3)) bus ();

    elevator_scheduler #(
        .NUM_FLOORS (NF),
        .FLOOR_W    (3),
        .MOVE_CYCLES(MC),
        .DOOR_CYCLES(DC)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    localparam int PH_IDLE = 0, PH_MOVE = 1, PH_DOOR = 2;
    logic [NF-1:0] m_pend  = '0;
    int            m_floor = 0;
    bit            m_dir   = 1'b1;
    int            m_phase = PH_IDLE;
    int            m_left  = 0;   // cycles left in the current trip leg or door period
    bit            m_arr   = 1'b0;

    function automatic int side(input logic [NF-1:0] p, input int f, input bit up);
        int n = 0;
        for (int i = 0; i < NF; i++) if (p[i] && (up ? (i > f) : (i < f))) n++;
        return n;
    endfunction

    task automatic m_reset();
        m_pend = '0; m_floor = 0; m_dir = 1'b1; m_phase = PH_IDLE; m_left = 0; m_arr = 1'b0;
    endtask

    // Continue in the current direction if calls remain, else turn round, else rest.
    task automatic m_leave(input logic [NF-1:0] p);
        if (side(p, m_floor, m_dir) > 0) begin
            m_phase = PH_MOVE; m_left = MC;
        end else if (side(p, m_floor, !m_dir) > 0) begin
            m_dir = !m_dir; m_phase = PH_MOVE; m_left = MC;
        end else begin
            m_phase = PH_IDLE;
        end
    endtask

    task automatic m_step();
        logic [NF-1:0] req, old;
        bit enter_door;
        req = bus.call_req; old = m_pend; enter_door = 1'b0; m_arr = 1'b0;
        if (m_phase == PH_DOOR) req[m_floor] = 1'b0;
        case (m_phase)
            PH_IDLE: begin
                if (old[m_floor]) begin
                    m_phase = PH_DOOR; m_left = DC; enter_door = 1'b1;
                end else if (side(old, m_floor, 1) + side(old, m_floor, 0) > 0) begin
                    m_dir = side(old, m_floor, 1) >= side(old, m_floor, 0);
                    m_phase = PH_MOVE; m_left = MC;
                end
            end
            PH_MOVE: begin
                m_left--;
                if (m_left == 0) begin
                    m_floor = m_dir ? m_floor + 1 : m_floor - 1;
                    m_arr = 1'b1;
                    if (old[m_floor]) begin
                        m_phase = PH_DOOR; m_left = DC; enter_door = 1'b1;
                    end else m_leave(old);
                end
            end
            default: begin
                if (bus.call_req[m_floor]) m_left = DC;
                else begin
                    m_left--;
                    if (m_left == 0) m_leave(old);
                end
            end
        endcase
        m_pend = old | req;
        if (enter_door) m_pend[m_floor] = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clock or negedge reset_n);
            if (!reset_n) m_reset();
            else m_step();
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clock);
            chk("model.pending",   bus.pending,       m_pend);
            chk("model.floor",     bus.current_floor, m_floor);
            chk("model.direction", bus.direction,     m_dir);
            chk("model.moving",    bus.moving,        m_phase == PH_MOVE);
            chk("model.door_open", bus.door_open,     m_phase == PH_DOOR);
            chk("model.arrived",   bus.arrived,       m_arr);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        #1 reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    // Drive a one-cycle call pulse from a negedge; returns on the next negedge.
    task automatic pulse(input logic [NF-1:0] v);
        bus.call_req = v;
        @(negedge clock);
        bus.call_req = '0;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (!bus.moving && !bus.door_open && bus.pending == '0) done = 1'b1;
            else @(negedge clock);
        end
        if (!done) begin
            n_checks++;
            $display("FAIL %s: car never came to rest within 400 cycles", name);
        end
    endtask

    int ef;

    initial begin
        reset_n      = 1'b1;
        bus.call_req = '0;
        #1 reset_n = 1'b0;
        @(negedge clock);
        chk("reset.pending",   bus.pending,       8'h00);
        chk("reset.floor",     bus.current_floor, 0);
        chk("reset.direction", bus.direction,     1);
        chk("reset.moving",    bus.moving,        0);
        chk("reset.door",      bus.door_open,     0);
        chk("reset.arrived",   bus.arrived,       0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // 1: single call to floor 5 from rest at 0
        pulse(8'h20);
        chk("s1.latched", bus.pending, 8'h20);
        chk("s1.latency", bus.moving,  0);
        @(negedge clock);
        for (int t = 0; t < 24; t++) begin
            ef = (t / 4 > 5) ? 5 : t / 4;
            chk("s1.moving",  bus.moving,        t < 20);
            chk("s1.arrived", bus.arrived,       (t > 0) && (t % 4 == 0));
            chk("s1.floor",   bus.current_floor, ef);
            chk("s1.door",    bus.door_open,     (t >= 20) && (t <= 22));
            @(negedge clock);
        end
        chk("s1.pending_end", bus.pending,   8'h00);
        chk("s1.dir_end",     bus.direction, 1);

        // 2: call at the floor the car rests on
        do_reset();
        pulse(8'h01);
        chk("s2.latched", bus.pending,   8'h01);
        chk("s2.no_door", bus.door_open, 0);
        @(negedge clock);
        for (int t = 0; t < 6; t++) begin
            chk("s2.door",    bus.door_open, t <= 2);
            chk("s2.moving",  bus.moving,    0);
            chk("s2.pending", bus.pending,   8'h00);
            @(negedge clock);
        end

        // 3: heading up to 6, call at 1 placed while passing 3
        do_reset();
        pulse(8'h40);
        @(negedge clock);
        for (int t = 0; t < 51; t++) begin
            if (t <= 24) ef = t / 4;
            else if (t < 27) ef = 6;
            else if (t < 47) ef = 6 - (t - 27) / 4;
            else ef = 1;
            chk("s3.floor",  bus.current_floor, ef);
            chk("s3.door",   bus.door_open, ((t >= 24) && (t <= 26)) || ((t >= 47) && (t <= 49)));
            chk("s3.moving", bus.moving,    (t < 24) || ((t >= 27) && (t < 47)));
            chk("s3.dir",    bus.direction, t < 27);
            if (t == 14) chk("s3.both_pending", bus.pending, 8'h42);
            bus.call_req = (t == 13) ? 8'h02 : 8'h00;
            @(negedge clock);
        end
        chk("s3.pending_end", bus.pending, 8'h00);

        // 4: direction choice from rest at floor 4
        do_reset();
        pulse(8'h10);
        wait_idle("s4.go4");
        chk("s4.at4", bus.current_floor, 4);
        pulse(8'h83);
        chk("s4.latched", bus.pending, 8'h83);
        @(negedge clock);
        chk("s4.more_below", bus.direction, 0);
        chk("s4.moving",     bus.moving,    1);
        wait_idle("s4.serve3");
        chk("s4.end_floor", bus.current_floor, 7);
        chk("s4.end_dir",   bus.direction,     1);
        pulse(8'h10);
        wait_idle("s4.back4");
        chk("s4.at4_again", bus.current_floor, 4);
        chk("s4.dir_down",  bus.direction,     0);
        pulse(8'h44);
        @(negedge clock);
        chk("s4.tie_up",    bus.direction, 1);
        chk("s4.tie_move",  bus.moving,    1);
        wait_idle("s4.tie");
        chk("s4.tie_floor", bus.current_floor, 2);
        chk("s4.tie_dir",   bus.direction,     0);

        // 5: door reload at floor 2
        pulse(8'h04);
        chk("s5.latched", bus.pending, 8'h04);
        @(negedge clock);
        for (int t = 0; t < 7; t++) begin
            chk("s5.door",    bus.door_open, t <= 4);
            chk("s5.pending", bus.pending,   8'h00);
            chk("s5.moving",  bus.moving,    0);
            bus.call_req = (t == 1) ? 8'h04 : 8'h00;
            @(negedge clock);
        end

        // 6: asynchronous reset between floors 3 and 4
        do_reset();
        pulse(8'h80);
        @(negedge clock);
        repeat (14) @(negedge clock);
        chk("s6.floor3", bus.current_floor, 3);
        chk("s6.moving", bus.moving,        1);
        #2 reset_n = 1'b0;
        #1;
        chk("s6.pending", bus.pending,       8'h00);
        chk("s6.floor",   bus.current_floor, 0);
        chk("s6.dir",     bus.direction,     1);
        chk("s6.moving0", bus.moving,        0);
        chk("s6.door",    bus.door_open,     0);
        chk("s6.arrived", bus.arrived,       0);
        @(negedge clock);
        reset_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clock);
            chk("s6.still",      bus.moving,        0);
            chk("s6.no_pending", bus.pending,       8'h00);
            chk("s6.stay0",      bus.current_floor, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
